bldcm_ramp_sequencer: RTL and testbench

//  Avalon-MM master that sequences the BLDC motor controller's slave register file.

---
 rtl/bldcm_ramp_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_bldcm_ramp_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bldcm_ramp_sequencer.sv
// Avalon-MM master that brings up the BLDC controller CSRs, ramps the frequency target
// step by step (waiting for each step to be reflected), and ramps back down on stop.
module bldcm_ramp_sequencer #(
    parameter logic [1:0] pAddrCtrl    = 2'd0,
    parameter logic [1:0] pAddrFreq    = 2'd1,
    parameter logic [1:0] pAddrPwm     = 2'd3,
    parameter int         pReflTimeout = 1024
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStart,
    input  logic        iStop,
    input  logic [31:0] iFreqInit,
    input  logic [31:0] iFreqFinal,
    input  logic [31:0] iFreqStep,
    input  logic [15:0] iDwell,
    input  logic [31:0] iPwmWord,
    output logic [1:0]  oAddr,
    output logic        oRead,
    output logic        oWrite,
    output logic [31:0] oWdata,
    input  logic [31:0] iRdata,
    input  logic [1:0]  iResp,
    output logic        oRunning,
    output logic        oBusy,
    output logic        oError,
    output logic [3:0]  oDbgState
);

    typedef enum logic [3:0] {
        sIdle  = 4'd0,
        sCfg   = 4'd1,
        sEna   = 4'd2,
        sWrf   = 4'd3,
        sPoll  = 4'd4,
        sDwell = 4'd5,
        sRun   = 4'd6,
        sDis   = 4'd7,
        sErr   = 4'd8
    } stateT;

    localparam logic [15:0] cTimeoutLast = 16'(pReflTimeout - 1);

    stateT       state;
    logic [31:0] freqInit;
    logic [31:0] freqFinal;
    logic [31:0] step;
    logic [15:0] dwell;
    logic [31:0] cur;
    logic [15:0] dwellCnt;
    logic [15:0] toCnt;
    logic        pollData;
    logic        dirDown;
    logic        stopPend;

    logic        dnEff;
    logic [32:0] upSum;
    logic [32:0] dnDiff;
    logic [31:0] nextCur;
    logic [31:0] startFreq;
    logic        unusedBits;

    assign oDbgState  = state;
    assign unusedBits = ^{iRdata[31:2], iRdata[0]};

    // Next ramp value in 33 bits so neither direction can wrap past its bound.
    always_comb begin
        dnEff   = dirDown | iStop;
        upSum   = {1'b0, cur} + {1'b0, step};
        dnDiff  = {1'b0, cur} - {1'b0, step};
        nextCur = cur;
        if (dnEff) begin
            if (dnDiff[32] || (dnDiff[31:0] <= freqInit)) nextCur = freqInit;
            else                                           nextCur = dnDiff[31:0];
        end else begin
            if (upSum >= {1'b0, freqFinal}) nextCur = freqFinal;
            else                            nextCur = upSum[31:0];
        end
        startFreq = (freqInit >= freqFinal) ? freqFinal : freqInit;
    end

    // Bus handshake: no waitrequest, so a strobe (oRead or oWrite) is held for exactly one
    // cycle; iResp is sampled in the write cycle, iRdata/iResp in the cycle after oRead.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state     <= sIdle;
            oRead     <= 1'b0;
            oWrite    <= 1'b0;
            oAddr     <= 2'd0;
            oWdata    <= 32'd0;
            oRunning  <= 1'b0;
            oBusy     <= 1'b0;
            oError    <= 1'b0;
            freqInit  <= 32'd0;
            freqFinal <= 32'd0;
            step      <= 32'd1;
            dwell     <= 16'd0;
            cur       <= 32'd0;
            dwellCnt  <= 16'd0;
            toCnt     <= 16'd0;
            pollData  <= 1'b0;
            dirDown   <= 1'b0;
            stopPend  <= 1'b0;
        end else begin
            oRead  <= 1'b0;
            oWrite <= 1'b0;
            case (state)
                sIdle: begin
                    if (iStart && !iStop) begin
                        freqInit  <= iFreqInit;
                        freqFinal <= iFreqFinal;
                        step      <= (iFreqStep == 32'd0) ? 32'd1 : iFreqStep;
                        dwell     <= iDwell;
                        dirDown   <= 1'b0;
                        stopPend  <= 1'b0;
                        oError    <= 1'b0;
                        oBusy     <= 1'b1;
                        oWrite    <= 1'b1;
                        oAddr     <= pAddrPwm;
                        oWdata    <= iPwmWord;
                        state     <= sCfg;
                    end
                end
                sCfg, sEna: begin
                    if (iResp != 2'b00) begin
                        oError   <= 1'b1;
                        oWrite   <= 1'b1;
                        oAddr    <= pAddrCtrl;
                        oWdata   <= 32'd0;
                        state    <= sErr;
                    end else if (iStop) begin
                        oWrite   <= 1'b1;
                        oAddr    <= pAddrCtrl;
                        oWdata   <= 32'd0;
                        state    <= sDis;
                    end else if (state == sCfg) begin
                        oWrite   <= 1'b1;
                        oAddr    <= pAddrCtrl;
                        oWdata   <= 32'h1;
                        state    <= sEna;
                    end else begin
                        cur      <= startFreq;
                        oWrite   <= 1'b1;
                        oAddr    <= pAddrFreq;
                        oWdata   <= startFreq;
                        state    <= sWrf;
                    end
                end
                sWrf: begin
                    if (iStop) begin
                        dirDown  <= 1'b1;
                        stopPend <= 1'b1;
                    end
                    if (iResp != 2'b00) begin
                        oError   <= 1'b1;
                        oWrite   <= 1'b1;
                        oAddr    <= pAddrCtrl;
                        oWdata   <= 32'd0;
                        state    <= sErr;
                    end else begin
                        oRead    <= 1'b1;
                        oAddr    <= pAddrCtrl;
                        toCnt    <= 16'd0;
                        pollData <= 1'b0;
                        state    <= sPoll;
                    end
                end
                sPoll: begin
                    toCnt <= toCnt + 16'd1;
                    if (iStop) begin
                        dirDown  <= 1'b1;
                        stopPend <= 1'b1;
                    end
                    if (!pollData) begin
                        pollData <= 1'b1;
                    end else if (iResp != 2'b00 || (!iRdata[1] && !iStop && !stopPend
                                                     && toCnt >= cTimeoutLast)) begin
                        oError   <= 1'b1;
                        oWrite   <= 1'b1;
                        oAddr    <= pAddrCtrl;
                        oWdata   <= 32'd0;
                        state    <= sErr;
                    end else if (iRdata[1] || iStop || stopPend) begin
                        // A pending stop abandons the wait once the read in flight has returned.
                        stopPend <= 1'b0;
                        dwellCnt <= 16'd0;
                        state    <= sDwell;
                    end else begin
                        pollData <= 1'b0;
                        oRead    <= 1'b1;
                        oAddr    <= pAddrCtrl;
                    end
                end
                sDwell: begin
                    if (iStop) dirDown <= 1'b1;
                    if (dwellCnt >= dwell) begin
                        if (!dnEff && cur >= freqFinal) begin
                            oRunning <= 1'b1;
                            state    <= sRun;
                        end else if (dnEff && cur <= freqInit) begin
                            oWrite   <= 1'b1;
                            oAddr    <= pAddrCtrl;
                            oWdata   <= 32'd0;
                            state    <= sDis;
                        end else begin
                            cur      <= nextCur;
                            oWrite   <= 1'b1;
                            oAddr    <= pAddrFreq;
                            oWdata   <= nextCur;
                            state    <= sWrf;
                        end
                    end else begin
                        dwellCnt <= dwellCnt + 16'd1;
                    end
                end
                sRun: begin
                    if (iStop) begin
                        dirDown  <= 1'b1;
                        oRunning <= 1'b0;
                        dwellCnt <= 16'd0;
                        state    <= sDwell;
                    end
                end
                sDis, sErr: begin
                    oRunning <= 1'b0;
                    oBusy    <= 1'b0;
                    state    <= sIdle;
                end
                default: begin
                    oRunning <= 1'b0;
                    oBusy    <= 1'b0;
                    state    <= sIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bldcm_ramp_sequencer.sv
// Directed bench for bldcm_ramp_sequencer: a CSR slave model with configurable reflection
// delay and error injection, plus a queue of expected {addr, data} writes.
module tb_bldcm_ramp_sequencer;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic        iStart = 1'b0;
    logic        iStop = 1'b0;
    logic [31:0] iFreqInit = '0;
    logic [31:0] iFreqFinal = '0;
    logic [31:0] iFreqStep = '0;
    logic [15:0] iDwell = '0;
    logic [31:0] iPwmWord = '0;
    logic [1:0]  oAddr;
    logic        oRead;
    logic        oWrite;
    logic [31:0] oWdata;
    logic [31:0] iRdata = '0;
    logic [1:0]  iResp = '0;
    logic        oRunning;
    logic        oBusy;
    logic        oError;
    logic [3:0]  oDbgState;

    int          nChecks = 0;
    int          nErrors = 0;
    int          cyc = 0;
    int          freqWrCyc = 0;
    int          readCount = 0;
    int          reflAfter = 2;
    bit          injectCfgErr = 1'b0;
    bit          rdPend = 1'b0;
    logic [33:0] expQ[$];

    bldcm_ramp_sequencer dut (
        .iClock(clk), .iReset(iReset), .iStart(iStart), .iStop(iStop),
        .iFreqInit(iFreqInit), .iFreqFinal(iFreqFinal), .iFreqStep(iFreqStep),
        .iDwell(iDwell), .iPwmWord(iPwmWord), .oAddr(oAddr), .oRead(oRead),
        .oWrite(oWrite), .oWdata(oWdata), .iRdata(iRdata), .iResp(iResp),
        .oRunning(oRunning), .oBusy(oBusy), .oError(oError), .oDbgState(oDbgState)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // slave model and write scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        iResp = 2'b00;
        if (oRead && oWrite) checkVal("rw_exclusive", 1, 0);
        if (oWrite) begin
            if (expQ.size() == 0) checkVal("wr_unexpected", {30'd0, oAddr, oWdata}, 64'd0);
            else checkVal("wr", {30'd0, oAddr, oWdata}, {30'd0, expQ.pop_front()});
            if (injectCfgErr && oAddr == 2'd3) iResp = 2'b10;
            if (oAddr == 2'd1) begin
                readCount = 0;
                freqWrCyc = cyc;
            end
        end
        if (rdPend) begin
            iRdata = {30'd0, (reflAfter != 0 && readCount >= reflAfter), 1'b0};
            rdPend = 1'b0;
        end
        if (oRead) begin
            readCount++;
            rdPend = 1'b1;
        end
    end

    // driver tasks
    task automatic pushWr(input logic [1:0] a, input logic [31:0] d);
        expQ.push_back({a, d});
    endtask

    task automatic startRamp(input logic [31:0] fi, input logic [31:0] ff,
                             input logic [31:0] fs, input logic [15:0] dw,
                             input logic [31:0] pwm);
        iFreqInit = fi; iFreqFinal = ff; iFreqStep = fs; iDwell = dw; iPwmWord = pwm;
        @(negedge clk) iStart = 1'b1;
        @(negedge clk) iStart = 1'b0;
    endtask

    task automatic pulseStop();
        @(negedge clk) iStop = 1'b1;
        @(negedge clk) iStop = 1'b0;
    endtask

    task automatic waitRunning(input string tag, input int budget);
        int n = 0;
        while (!oRunning && n < budget) begin @(negedge clk); n++; end
        checkVal(tag, oRunning, 1);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (oBusy && n < budget) begin @(negedge clk); n++; end
        checkVal(tag, oBusy, 0);
    endtask

    initial begin
        logic [31:0] pwm;
        int n;
        repeat (3) @(negedge clk);
        iReset = 1'b0;
        @(negedge clk);
        checkVal("reset_outputs", {oRead, oWrite, oAddr, oWdata, oRunning, oBusy, oError}, 0);
        checkVal("reset_state", oDbgState, 0);

        // ramp 100..400 by 100, reflected on the second read
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h1);
        pushWr(2'd1, 100); pushWr(2'd1, 200); pushWr(2'd1, 300); pushWr(2'd1, 400);
        startRamp(100, 400, 100, 4, pwm);
        checkVal("busy_after_start", oBusy, 1);
        waitRunning("run_400", 400);
        checkVal("run_q_drained", expQ.size(), 0);
        checkVal("run_no_error", oError, 0);
        pushWr(2'd1, 300); pushWr(2'd1, 200); pushWr(2'd1, 100); pushWr(2'd0, 32'h0);
        pulseStop();
        checkVal("stop_clears_running", oRunning, 0);
        waitIdle("idle_after_stop", 400);
        checkVal("stop_q_drained", expQ.size(), 0);
        checkVal("stop_state_idle", oDbgState, 0);

        // up ramp clamps at 350, down ramp clamps at 100
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h1);
        pushWr(2'd1, 100); pushWr(2'd1, 200); pushWr(2'd1, 300); pushWr(2'd1, 350);
        startRamp(100, 350, 100, 0, pwm);
        waitRunning("run_350", 400);
        pushWr(2'd1, 250); pushWr(2'd1, 150); pushWr(2'd1, 100); pushWr(2'd0, 32'h0);
        pulseStop();
        waitIdle("idle_after_350", 400);
        checkVal("clamp_q_drained", expQ.size(), 0);

        // zero step behaves as one
        reflAfter = 1;
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h1);
        pushWr(2'd1, 10); pushWr(2'd1, 11); pushWr(2'd1, 12);
        startRamp(10, 12, 0, 1, pwm);
        waitRunning("run_step0", 200);
        pushWr(2'd1, 11); pushWr(2'd1, 10); pushWr(2'd0, 32'h0);
        pulseStop();
        waitIdle("idle_step0", 200);
        checkVal("step0_q_drained", expQ.size(), 0);

        // init above final: single write of final, then straight to disable on stop
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h1); pushWr(2'd1, 300);
        startRamp(500, 300, 50, 2, pwm);
        waitRunning("run_inverted", 200);
        pushWr(2'd0, 32'h0);
        pulseStop();
        waitIdle("idle_inverted", 200);
        checkVal("inverted_q_drained", expQ.size(), 0);

        // reflection never arrives: timeout to ERR
        reflAfter = 0;
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h1); pushWr(2'd1, 100); pushWr(2'd0, 32'h0);
        startRamp(100, 200, 50, 1, pwm);
        n = 0;
        while (!oError && n < 1200) begin @(negedge clk); n++; end
        checkVal("timeout_error", oError, 1);
        checkVal("timeout_window", ((cyc - freqWrCyc) >= 1020 && (cyc - freqWrCyc) <= 1030), 1);
        waitIdle("idle_after_timeout", 20);
        checkVal("error_sticky", oError, 1);
        checkVal("timeout_q_drained", expQ.size(), 0);

        // a new start clears the sticky error
        reflAfter = 1;
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h1); pushWr(2'd1, 100);
        startRamp(100, 100, 10, 0, pwm);
        checkVal("start_clears_error", oError, 0);
        waitRunning("run_after_error", 100);
        pushWr(2'd0, 32'h0);
        pulseStop();
        waitIdle("idle_after_error", 100);

        // bad response on the PWM write
        injectCfgErr = 1'b1;
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h0);
        startRamp(100, 400, 100, 0, pwm);
        waitIdle("idle_after_resp_err", 50);
        checkVal("resp_error", oError, 1);
        checkVal("resp_q_drained", expQ.size(), 0);
        injectCfgErr = 1'b0;

        // start and stop together in IDLE: stop wins, nothing happens
        @(negedge clk) begin iStart = 1'b1; iStop = 1'b1; end
        @(negedge clk) begin iStart = 1'b0; iStop = 1'b0; end
        repeat (3) @(negedge clk);
        checkVal("start_stop_idle", oBusy, 0);
        checkVal("start_stop_state", oDbgState, 0);

        // reset while polling: everything back to reset values, no disable write
        reflAfter = 0;
        pwm = $urandom_range(1, 65535);
        pushWr(2'd3, pwm); pushWr(2'd0, 32'h1); pushWr(2'd1, 100);
        startRamp(100, 400, 100, 0, pwm);
        n = 0;
        while (oDbgState != 4'd4 && n < 50) begin @(negedge clk); n++; end
        checkVal("reached_poll", oDbgState, 4);
        repeat (3) @(negedge clk);
        iReset = 1'b1;
        @(negedge clk);
        checkVal("reset_in_poll", {oRead, oWrite, oAddr, oWdata, oRunning, oBusy, oError}, 0);
        iReset = 1'b0;
        repeat (5) @(negedge clk);
        checkVal("stay_idle_after_reset", oBusy, 0);
        checkVal("reset_q_drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
